// File: rtl/lzw_forward_byte_reverse.sv
// Byte-group reversal stage for the LZW compress path. Groups of 1..31 bytes land in
// a two-bank ping-pong buffer and are played back last-byte-first with a length side-channel.
module lzw_forward_byte_reverse (
    input  logic       I_sys_clk,
    input  logic       I_sys_rst,
    input  logic       I_state_clr,
    input  logic [7:0] I_string_data,
    input  logic       I_string_data_en,
    input  logic       I_string_eop,
    output logic       O_string_ready,
    output logic [7:0] O_dictionary_send_data,
    output logic       O_dictionary_send_data_en,
    output logic       O_reverse_byte_flag,
    output logic [4:0] O_reverse_byte_num,
    output logic       O_reverse_byte_num_wren,
    output logic [15:0] O_group_cnt,
    output logic [15:0] O_split_cnt
);

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    logic [7:0]  mem [0:63];
    logic [7:0]  data_q;

    logic [1:0]  f_q, f_d;
    logic [4:0]  len_q [2];
    logic [4:0]  len_d [2];
    logic        wb_q, wb_d;
    logic        rb_q, rb_d;
    logic [4:0]  wi_q, wi_d;
    logic [4:0]  ri_q, ri_d;
    state_t      state_q, state_d;

    logic        ready_q, ready_d;
    logic        den_q, den_d;
    logic        flag_q, flag_d;
    logic [4:0]  num_q, num_d;
    logic        wren_q, wren_d;
    logic [15:0] group_cnt_q, group_cnt_d;
    logic [15:0] split_cnt_q, split_cnt_d;

    logic        accept, wr_close, wr_split, wr_at_limit;
    logic        rd_en, rd_last;
    logic [5:0]  wr_addr, rd_addr;
    logic [4:0]  rd_len;

    // ---------------- write side ----------------
    always_comb begin
        accept      = I_string_data_en & ~f_q[wb_q];
        wr_at_limit = (wi_q == 5'd30);
        wr_close    = accept & (I_string_eop | wr_at_limit);
        wr_split    = accept & ~I_string_eop & wr_at_limit;
        wr_addr     = {wb_q, wi_q};
        wi_d        = wi_q;
        if (wr_close)
            wi_d = 5'd0;
        else if (accept)
            wi_d = wi_q + 5'd1;
        wb_d        = wb_q ^ wr_close;
    end

    // Writer and reader never touch the same bank's flag in one cycle: a full bank blocks writes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign f_d[gi]   = (wr_close && wb_q == 1'(gi)) ? 1'b1 :
                               (rd_last  && rb_q == 1'(gi)) ? 1'b0 : f_q[gi];
            assign len_d[gi] = (wr_close && wb_q == 1'(gi)) ? wi_q + 5'd1 : len_q[gi];
        end
    endgenerate

    assign ready_d = ~f_d[wb_d];

    // ---------------- read FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        ri_d    = ri_q;
        rb_d    = rb_q;
        case (state_q)
            ST_IDLE: begin
                if (f_q[rb_q]) begin
                    state_d = ST_EMIT;
                    ri_d    = len_q[rb_q] - 5'd1;
                end
            end
            ST_EMIT: begin
                if (ri_q != 5'd0) begin
                    ri_d = ri_q - 5'd1;
                end else begin
                    rb_d = ~rb_q;
                    // Chain straight into the other bank when it is already waiting.
                    if (f_q[~rb_q])
                        ri_d = len_q[~rb_q] - 5'd1;
                    else
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- read FSM: outputs ----------------
    always_comb begin
        rd_en   = (state_q == ST_EMIT);
        rd_last = rd_en && (ri_q == 5'd0);
        rd_len  = len_q[rb_q];
        rd_addr = {rb_q, ri_q};
        den_d   = rd_en;
        flag_d  = rd_en && (rd_len != 5'd1);
        wren_d  = rd_en && (rd_len != 5'd1) && (ri_q == rd_len - 5'd1);
        num_d   = wren_d ? rd_len : 5'd0;

        group_cnt_d = group_cnt_q;
        if (I_state_clr)
            group_cnt_d = 16'd0;
        else if (rd_last && group_cnt_q != 16'hFFFF)
            group_cnt_d = group_cnt_q + 16'd1;

        split_cnt_d = split_cnt_q;
        if (I_state_clr)
            split_cnt_d = 16'd0;
        else if (wr_split && split_cnt_q != 16'hFFFF)
            split_cnt_d = split_cnt_q + 16'd1;
    end

    // ---------------- buffer RAM ----------------
    always_ff @(posedge I_sys_clk) begin
        if (accept)
            mem[wr_addr] <= I_string_data;
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst)
            data_q <= 8'd0;
        else if (rd_en)
            data_q <= mem[rd_addr];
    end

    // ---------------- state registers ----------------
    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            f_q         <= 2'b00;
            len_q[0]    <= 5'd1;
            len_q[1]    <= 5'd1;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wi_q        <= 5'd0;
            ri_q        <= 5'd0;
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            den_q       <= 1'b0;
            flag_q      <= 1'b0;
            num_q       <= 5'd0;
            wren_q      <= 1'b0;
            group_cnt_q <= 16'd0;
            split_cnt_q <= 16'd0;
        end else begin
            f_q         <= f_d;
            len_q[0]    <= len_d[0];
            len_q[1]    <= len_d[1];
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wi_q        <= wi_d;
            ri_q        <= ri_d;
            state_q     <= state_d;
            ready_q     <= ready_d;
            den_q       <= den_d;
            flag_q      <= flag_d;
            num_q       <= num_d;
            wren_q      <= wren_d;
            group_cnt_q <= group_cnt_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    assign O_string_ready            = ready_q;
    assign O_dictionary_send_data    = data_q;
    assign O_dictionary_send_data_en = den_q;
    assign O_reverse_byte_flag       = flag_q;
    assign O_reverse_byte_num        = num_q;
    assign O_reverse_byte_num_wren   = wren_q;
    assign O_group_cnt               = group_cnt_q;
    assign O_split_cnt               = split_cnt_q;

endmodule

// File: tb/tb_lzw_forward_byte_reverse.sv
// Directed bench for lzw_forward_byte_reverse: feeds byte groups, collects the
// reversed stream on the falling edge and compares against hand-computed vectors.
module tb_lzw_forward_byte_reverse;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        state_clr = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_en = 1'b0;
    logic        s_eop = 1'b0;
    logic        s_ready;
    logic [7:0]  d_data;
    logic        d_en;
    logic        r_flag;
    logic [4:0]  r_num;
    logic        r_wren;
    logic [15:0] grp_cnt;
    logic [15:0] spl_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_acc = 0;
    bit saw_not_ready = 1'b0;

    logic [7:0] q_data[$];
    logic       q_flag[$];
    int         q_cyc[$];
    logic [4:0] q_num[$];
    int         q_ncyc[$];
    logic [7:0] tx_data[$];
    logic       tx_eop[$];
    logic [7:0] exp_data[$];
    logic [4:0] exp_num[$];

    lzw_forward_byte_reverse dut (
        .I_sys_clk                 (clk),
        .I_sys_rst                 (sys_rst),
        .I_state_clr               (state_clr),
        .I_string_data             (s_data),
        .I_string_data_en          (s_en),
        .I_string_eop              (s_eop),
        .O_string_ready            (s_ready),
        .O_dictionary_send_data    (d_data),
        .O_dictionary_send_data_en (d_en),
        .O_reverse_byte_flag       (r_flag),
        .O_reverse_byte_num        (r_num),
        .O_reverse_byte_num_wren   (r_wren),
        .O_group_cnt               (grp_cnt),
        .O_split_cnt               (spl_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d_en) begin
            q_data.push_back(d_data);
            q_flag.push_back(r_flag);
            q_cyc.push_back(cyc);
        end
        if (r_wren) begin
            q_num.push_back(r_num);
            q_ncyc.push_back(cyc);
        end
        if (!s_ready) saw_not_ready = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete(); q_flag.delete(); q_cyc.delete();
        q_num.delete(); q_ncyc.delete();
    endtask

    task automatic pulse_clr();
        state_clr = 1'b1;
        tick();
        state_clr = 1'b0;
    endtask

    task automatic send_stream();
        int i = 0;
        int budget = 0;
        bit r;
        while (i < tx_data.size()) begin
            s_data = tx_data[i];
            s_eop  = tx_eop[i];
            s_en   = 1'b1;
            r = s_ready;
            tick();
            if (r) begin
                last_acc = cyc;
                i++;
            end
            budget++;
            if (budget > 2000) begin
                n_checks++;
                $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, tx_data.size());
                break;
            end
        end
        s_en  = 1'b0;
        s_eop = 1'b0;
        $display("sent %0d bytes, last accepted at cycle %0d", tx_data.size(), last_acc);
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        repeat (4) tick();
        ok = (q_data.size() >= n);
    endtask

    task automatic load_range(input int first, input int count, input bit eop_last);
        tx_data.delete(); tx_eop.delete();
        for (int i = 0; i < count; i++) begin
            tx_data.push_back(8'(first + i));
            tx_eop.push_back(eop_last && (i == count - 1));
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (d_en !== 1'b0) $display("FAIL reset_data_en: got %b want 0", d_en); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", s_ready); else n_pass++;
        n_checks++; if (r_wren !== 1'b0 || r_num !== 5'd0 || r_flag !== 1'b0)
            $display("FAIL reset_side: wren=%b num=%0d flag=%b want 0/0/0", r_wren, r_num, r_flag); else n_pass++;
        n_checks++; if (d_data !== 8'h00) $display("FAIL reset_data: got %h want 00", d_data); else n_pass++;
        n_checks++; if (grp_cnt !== 16'd0 || spl_cnt !== 16'd0)
            $display("FAIL reset_cnt: grp=%0d split=%0d want 0/0", grp_cnt, spl_cnt); else n_pass++;
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_five();
        bit ok;
        logic [7:0] exp_b;
        int acc;
        clear_mon();
        tx_data.delete(); tx_eop.delete();
        for (int i = 0; i < 5; i++) begin
            tx_data.push_back(8'(8'h11 * (i + 1)));
            tx_eop.push_back(i == 4);
        end
        send_stream();
        acc = last_acc;
        wait_out(5, 50, ok);
        n_checks++; if (q_data.size() !== 5) $display("FAIL five_count: got %0d bytes want 5", q_data.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                exp_b = 8'(8'h11 * (5 - i));
                n_checks++; if (q_data[i] !== exp_b) $display("FAIL five_byte%0d: got %h want %h", i, q_data[i], exp_b); else n_pass++;
                n_checks++; if (q_flag[i] !== 1'b1) $display("FAIL five_flag%0d: got %b want 1", i, q_flag[i]); else n_pass++;
                n_checks++; if (q_cyc[i] !== acc + 2 + i) $display("FAIL five_cycle%0d: got %0d want %0d", i, q_cyc[i], acc + 2 + i); else n_pass++;
            end
            n_checks++; if (q_num.size() !== 1) $display("FAIL five_wren_count: got %0d want 1", q_num.size()); else n_pass++;
            if (q_num.size() > 0) begin
                n_checks++; if (q_num[0] !== 5'd5) $display("FAIL five_num: got %0d want 5", q_num[0]); else n_pass++;
                n_checks++; if (q_ncyc[0] !== q_cyc[0]) $display("FAIL five_num_align: got cycle %0d want %0d", q_ncyc[0], q_cyc[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        pulse_clr();
        clear_mon();
        tx_data.delete(); tx_eop.delete();
        tx_data.push_back(8'hA5); tx_eop.push_back(1'b1);
        send_stream();
        wait_out(1, 50, ok);
        n_checks++; if (q_data.size() !== 1) $display("FAIL single_count: got %0d want 1", q_data.size()); else n_pass++;
        if (ok) begin
            n_checks++; if (q_data[0] !== 8'hA5) $display("FAIL single_byte: got %h want a5", q_data[0]); else n_pass++;
            n_checks++; if (q_flag[0] !== 1'b0) $display("FAIL single_flag: got %b want 0", q_flag[0]); else n_pass++;
        end
        n_checks++; if (q_num.size() !== 0) $display("FAIL single_wren: got %0d pulses want 0", q_num.size()); else n_pass++;
        n_checks++; if (grp_cnt !== 16'd1) $display("FAIL single_grp_cnt: got %0d want 1", grp_cnt); else n_pass++;
    endtask

    task automatic test_full31();
        bit ok;
        pulse_clr();
        clear_mon();
        load_range(1, 31, 1'b1);
        send_stream();
        wait_out(31, 120, ok);
        n_checks++; if (q_data.size() !== 31) $display("FAIL full31_count: got %0d want 31", q_data.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 31; i++) begin
                n_checks++; if (q_data[i] !== 8'(31 - i)) $display("FAIL full31_byte%0d: got %h want %h", i, q_data[i], 8'(31 - i)); else n_pass++;
            end
        end
        n_checks++; if (q_num.size() !== 1 || q_num[0] !== 5'd31)
            $display("FAIL full31_num: got %0d pulses first=%0d want 1 pulse of 31", q_num.size(), (q_num.size() > 0) ? q_num[0] : 5'd0); else n_pass++;
        n_checks++; if (spl_cnt !== 16'd0) $display("FAIL full31_split: got %0d want 0", spl_cnt); else n_pass++;
    endtask

    task automatic test_split();
        bit ok;
        logic [7:0] e;
        pulse_clr();
        n_checks++; if (grp_cnt !== 16'd0) $display("FAIL clr_grp_cnt: got %0d want 0", grp_cnt); else n_pass++;
        clear_mon();
        load_range(0, 40, 1'b1);
        send_stream();
        wait_out(40, 200, ok);
        n_checks++; if (q_data.size() !== 40) $display("FAIL split_count: got %0d want 40", q_data.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 40; i++) begin
                e = (i < 31) ? 8'(30 - i) : 8'(39 - (i - 31));
                n_checks++; if (q_data[i] !== e || q_flag[i] !== 1'b1)
                    $display("FAIL split_byte%0d: got %h flag %b want %h flag 1", i, q_data[i], q_flag[i], e); else n_pass++;
            end
        end
        n_checks++; if (q_num.size() !== 2) $display("FAIL split_wren_count: got %0d want 2", q_num.size());
        else begin
            n_pass++;
            n_checks++; if (q_num[0] !== 5'd31 || q_num[1] !== 5'd9)
                $display("FAIL split_nums: got %0d,%0d want 31,9", q_num[0], q_num[1]); else n_pass++;
        end
        n_checks++; if (spl_cnt !== 16'd1) $display("FAIL split_cnt: got %0d want 1", spl_cnt); else n_pass++;
        n_checks++; if (grp_cnt !== 16'd2) $display("FAIL split_grp_cnt: got %0d want 2", grp_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        pulse_clr();
        clear_mon();
        saw_not_ready = 1'b0;
        tx_data.delete(); tx_eop.delete();
        exp_data.delete(); exp_num.delete();
        for (int i = 0; i < 31; i++) begin
            tx_data.push_back(8'(8'h80 + i));
            tx_eop.push_back(i == 30);
        end
        for (int i = 30; i >= 0; i--) exp_data.push_back(8'(8'h80 + i));
        exp_num.push_back(5'd31);
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 3; j++) begin
                tx_data.push_back(8'(3 * g + j + 1));
                tx_eop.push_back(j == 2);
            end
            for (int j = 2; j >= 0; j--) exp_data.push_back(8'(3 * g + j + 1));
            exp_num.push_back(5'd3);
        end
        send_stream();
        wait_out(exp_data.size(), 300, ok);
        n_checks++; if (q_data.size() !== exp_data.size())
            $display("FAIL b2b_count: got %0d want %0d", q_data.size(), exp_data.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < exp_data.size(); i++) begin
                n_checks++; if (q_data[i] !== exp_data[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, q_data[i], exp_data[i]); else n_pass++;
            end
        end
        n_checks++; if (q_num.size() !== exp_num.size()) $display("FAIL b2b_wren_count: got %0d want %0d", q_num.size(), exp_num.size());
        else begin
            n_pass++;
            for (int i = 0; i < exp_num.size(); i++) begin
                n_checks++; if (q_num[i] !== exp_num[i]) $display("FAIL b2b_num%0d: got %0d want %0d", i, q_num[i], exp_num[i]); else n_pass++;
            end
        end
        n_checks++; if (saw_not_ready !== 1'b1) $display("FAIL b2b_ready_drop: got %b want 1", saw_not_ready); else n_pass++;
        n_checks++; if (grp_cnt !== 16'd5) $display("FAIL b2b_grp_cnt: got %0d want 5", grp_cnt); else n_pass++;

        pulse_clr();
        n_checks++; if (grp_cnt !== 16'd0 || spl_cnt !== 16'd0)
            $display("FAIL b2b_clr: grp=%0d split=%0d want 0/0", grp_cnt, spl_cnt); else n_pass++;
        clear_mon();
        load_range(8'h61, 3, 1'b1);
        send_stream();
        wait_out(3, 50, ok);
        n_checks++; if (!ok || q_data[0] !== 8'h63 || q_data[1] !== 8'h62 || q_data[2] !== 8'h61)
            $display("FAIL after_clr_bytes: got %0d bytes, first %h want 63,62,61", q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'h00); else n_pass++;
        n_checks++; if (grp_cnt !== 16'd1) $display("FAIL after_clr_grp_cnt: got %0d want 1", grp_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        load_range(8'h30, 10, 1'b1);
        send_stream();
        wait_out(1, 50, ok);
        sys_rst = 1'b1;
        tick();
        n_checks++; if (d_en !== 1'b0) $display("FAIL midrst_data_en: got %b want 0", d_en); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", s_ready); else n_pass++;
        sys_rst = 1'b0;
        tick();
        clear_mon();
        repeat (15) tick();
        n_checks++; if (q_data.size() !== 0) $display("FAIL midrst_residue: got %0d bytes want 0", q_data.size()); else n_pass++;
        tx_data.delete(); tx_eop.delete();
        tx_data.push_back(8'hAB); tx_eop.push_back(1'b0);
        tx_data.push_back(8'hCD); tx_eop.push_back(1'b1);
        send_stream();
        wait_out(2, 50, ok);
        n_checks++; if (q_data.size() !== 2) $display("FAIL midrst_count: got %0d want 2", q_data.size()); else n_pass++;
        if (ok) begin
            n_checks++; if (q_data[0] !== 8'hCD || q_data[1] !== 8'hAB)
                $display("FAIL midrst_bytes: got %h,%h want cd,ab", q_data[0], q_data[1]); else n_pass++;
        end
        n_checks++; if (q_num.size() !== 1 || q_num[0] !== 5'd2)
            $display("FAIL midrst_num: got %0d pulses first=%0d want 1 pulse of 2", q_num.size(), (q_num.size() > 0) ? q_num[0] : 5'd0); else n_pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_five();
        repeat (5) tick();
        test_single();
        repeat (5) tick();
        test_full31();
        repeat (5) tick();
        test_split();
        repeat (5) tick();
        test_back_to_back();
        repeat (5) tick();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lzw_forward_byte_reverse.md
# lzw_forward_byte_reverse

Compress-side counterpart of the backward byte-reverse stage: sits in the LZW forward (compress) path, between the string/dictionary emitter and the dictionary send interface. Collects each delimited byte group of 1..31 bytes, emits the group in reverse byte order, tags each byte with a reverse flag, and writes the group length into a length side-channel. The backward decompressor restores the original order from these.

## Interface
- No parameters; group length limit fixed at 31 (5-bit length field), buffer fixed at 2 banks x 32 bytes.
- I_sys_clk  in  1  system clock, 250 MHz
- I_sys_rst  in  1  synchronous, active-high reset
- I_state_clr  in  1  clears statistic counters only
- I_string_data  in  8  input byte
- I_string_data_en  in  1  input byte valid; accepted only when O_string_ready=1
- I_string_eop  in  1  last byte of group; qualified by I_string_data_en
- O_string_ready  out  1  input may be accepted this cycle
- O_dictionary_send_data  out  8  output byte, reversed within group
- O_dictionary_send_data_en  out  1  output byte valid
- O_reverse_byte_flag  out  1  1 = byte belongs to a reversed group (length>=2)
- O_reverse_byte_num  out  5  group length, valid with O_reverse_byte_num_wren
- O_reverse_byte_num_wren  out  1  one-cycle length write pulse
- O_group_cnt  out  16  groups emitted since reset/clear, saturating
- O_split_cnt  out  16  forced group splits since reset/clear, saturating

## Operation
- Ping-pong buffer: banks 0/1, each 32x8 plus 5-bit length L[b] and full flag F[b]. Write pointer WB, read pointer RB, write index WI (5 bits).
- Write side: accepted byte stored at bank WB, address WI; WI++. Group closes on accepted byte with I_string_eop=1, or when the accepted byte makes WI reach 31 without eop (forced split, O_split_cnt++). On close: L[WB]=WI+1, F[WB]=1, WB toggles, WI=0.
- O_string_ready = ~F[WB]. Bytes presented with ready=0 are not accepted; upstream holds them.
- Read FSM states: IDLE, EMIT.
  - IDLE: if F[RB]=1 -> EMIT, read index RI = L[RB]-1.
  - EMIT: each cycle reads bank RB at RI, RI-- ; after index 0 is emitted, F[RB]=0, RB toggles, -> IDLE (or direct to EMIT on next bank if F of that bank already 1; no bubble required but allowed at most one cycle).
- Flag: O_reverse_byte_flag=1 for every byte of a group with L>=2; 0 for L=1.
- Length write: O_reverse_byte_num_wren pulses once per group with L>=2, coincident with the group's first output byte; O_reverse_byte_num=L. No length write for L=1.
- O_group_cnt++ on the last output byte of every group.
- Statistic counters saturate at 16'hFFFF; I_state_clr zeroes both (clear wins over simultaneous increment). Datapath unaffected by I_state_clr.
- Width rules: L in 1..31, never 0; RI arithmetic 5-bit, never wraps below 0.

## Timing
- Reset: all outputs 0 except O_string_ready=1; F=0, WB=RB=0, WI=0, FSM IDLE; buffered bytes discarded. Reset mid-group or mid-emission aborts silently; no partial-group output after release.
- Latency: group closed at cycle t -> first output byte at t+2 (registered RAM read), assuming reader idle; thereafter one byte per cycle, no gaps inside a group.
- All outputs registered; data, data_en, flag, num, num_wren aligned on the same cycle.
- Simultaneous write-close on one bank and read-release of the other bank in the same cycle: both take effect; ready stays 1.
- Writer closing into bank RB while reader releases it in the same cycle is impossible by construction (F blocks writes).
- Sustained throughput: 1 byte/cycle in and out; ready drops only when both banks full.

## Test plan
- Group 0x11,0x22,0x33,0x44,0x55 with eop on 0x55 -> out 55,44,33,22,11 at t+2..t+6, flag=1, num_wren once with num=5 on byte 0x55.
- Single byte 0xA5 with eop -> out A5, flag=0, no num_wren; O_group_cnt=1.
- 31 bytes 0x01..0x1F, eop on last -> out 1F..01, num=31, O_split_cnt=0.
- 40 bytes 0x00..0x27, eop on 0x27 -> group 1E..00 (num=31), then 27..1F (num=9); O_split_cnt=1, O_group_cnt=2.
- Back-to-back 3-byte groups at full rate with output stalled by long prior group -> ready drops when both banks full, no byte lost or duplicated; pulse I_state_clr -> both counters 0, next group output unchanged.
- Assert I_sys_rst during emission of a 10-byte group -> data_en=0 next cycle, ready=1; new 2-byte group 0xAB,0xCD -> out CD,AB, num=2.
